// File: rtl/multiword_addsub_ctrl.sv
// Multi-byte add/subtract sequencer: one shared 8-bit adder slice, one byte per clock, LSB first.
// Operands are latched on start; result, carry/borrow and signed overflow are published on completion.
module multiword_addsub_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [8*WORDS-1:0]   a,
    input  logic [8*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [8*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 ovf
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_next;
    logic [WORDS-1:0][7:0]   opa, opb, work, work_next;
    logic                    carry;
    logic                    sub_q;
    logic [IW-1:0]           idx;
    logic [8:0]              slice;
    logic                    last;

    // Shared byte slice: carry-in comes from the registered carry chain.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        work_next      = work;
        slice          = {1'b0, opa[idx]} + {1'b0, opb[idx]} + {8'b0, carry};
        work_next[idx] = slice[7:0];
        last           = (idx == IW'(WORDS - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            work   <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
                    opa   <= a;
                    opb   <= sub ? ~b : b;
                    carry <= sub;
                    sub_q <= sub;
                    idx   <= '0;
                end
                RUN: begin
                    work  <= work_next;
                    carry <= slice[8];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        result <= work_next;
                        cout   <= sub_q ? ~slice[8] : slice[8];
                        ovf    <= (opa[WORDS-1][7] == opb[WORDS-1][7]) &&
                                  (work_next[WORDS-1][7] != opa[WORDS-1][7]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
